// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte
// producers. Captures one byte from the granted requester and pulses tx_start.
// It then waits for tx_done, or for the optional watchdog, before it serves the
// next request.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req, req_data     per-requester valid and byte (slice i = req_data[i*DATA_W +: DATA_W])
//   grant             one-hot pulse, byte of requester i captured
//   tx_start, tx_din  launch pulse and byte to the serializer
//   tx_done           serializer completion pulse
//   busy              transfer in progress (LAUNCH or WAIT)
//   active_id         current/last granted requester
//   timeout_err       pulse when the watchdog aborts a transfer
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_din,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       timeout_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic                tx_start_d;
  logic [DATA_W-1:0]   tx_din_d;
  logic                busy_d;
  logic [ID_W-1:0]     active_d;
  logic                timeout_d;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     rr_next;

  // First active request scanning from rr_q upward with explicit wrap.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = rr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Last winner drops to lowest priority.
  assign rr_next = (active_id == ID_LAST) ? '0 : active_id + ID_W'(1);

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wd_d       = wd_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din;
    active_d   = active_id;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d  = NUM_REQ'(1) << winner;
          tx_din_d = req_data[32'(winner)*DATA_W +: DATA_W];
          active_d = winner;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_start_d = 1'b1;
        wd_d       = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (tx_done) begin
          rr_d    = rr_next;
          state_d = ST_IDLE;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          timeout_d = 1'b1;
          rr_d      = rr_next;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      wd_q        <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      busy        <= 1'b0;
      active_id   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wd_q        <= wd_d;
      grant       <= grant_d;
      tx_start    <= tx_start_d;
      tx_din      <= tx_din_d;
      busy        <= busy_d;
      active_id   <= active_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=20).
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 20;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_din;
  logic                      tx_done;
  logic                      busy;
  logic [1:0]                active_id;
  logic                      timeout_err;

  int n_chk = 0;
  int n_pass = 0;
  int cnt_busy = 0;
  int cnt_start = 0;
  int cnt_grant = 0;
  int cnt_to = 0;
  int onehot_bad = 0;
  int start_bad = 0;
  logic [NUM_REQ-1:0] grant_prev = '0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .tx_start   (tx_start),
    .tx_din     (tx_din),
    .tx_done    (tx_done),
    .busy       (busy),
    .active_id  (active_id),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) cnt_busy++;
    if (tx_start) cnt_start++;
    if (grant != '0) cnt_grant++;
    if (timeout_err) cnt_to++;
    if ($countones(grant) > 1) onehot_bad++;
    if (tx_start && grant_prev == '0) start_bad++;
    grant_prev = grant;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (grant != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) idx = i;
        break;
      end
    end
    check("grant_seen", 32'(grant != '0), 32'd1);
  endtask

  // Launch cycle, then tx_done visible lat cycles after the tx_start cycle.
  task automatic serve(input int lat);
    tick();
    repeat (lat) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int idx;
    int k;
    int s0;
    int t0;
    reset = 1'b1;
    req = '0;
    req_data = '0;
    tx_done = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Single requester 2, byte 0xA5, done 10 cycles after tx_start.
    req = 4'b0100;
    req_data[2*DATA_W +: DATA_W] = 8'hA5;
    cnt_busy = 0; cnt_start = 0; cnt_grant = 0;
    wait_grant(idx);
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_tx_din", 32'(tx_din), 32'hA5);
    check("t1_active_id", 32'(active_id), 32'd2);
    req = '0;
    serve(10);
    check("t1_busy_cycles", 32'(cnt_busy), 32'd12);
    check("t1_starts", 32'(cnt_start), 32'd1);
    check("t1_grants", 32'(cnt_grant), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // All four held, each re-presenting a new byte after its grant.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'(i * 16);
    req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_grant(idx);
      check("t2_order", 32'(idx), 32'(g % 4));
      check("t2_tx_din", 32'(tx_din), 32'((g % 4) * 16 + g / 4));
      if (idx >= 0) req_data[idx*DATA_W +: DATA_W] = 8'(idx * 16 + g / 4 + 1);
      serve(2);
    end

    // Pointer sits at 0 after serving 3: 0 wins, then 3.
    req = 4'b1001;
    wait_grant(idx);
    check("t3_wrap0", 32'(idx), 32'd0);
    serve(2);
    wait_grant(idx);
    check("t3_then3", 32'(idx), 32'd3);
    req = '0;
    serve(2);

    // Watchdog: requester 1 never completes, then requester 2 is served.
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b0010;
    wait_grant(idx);
    check("t4_grant1", 32'(idx), 32'd1);
    req = 4'b0100;
    tick();
    check("t4_tx_start", 32'(tx_start), 32'd1);
    s0 = cnt_start;
    t0 = -1;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (timeout_err) begin
        t0 = k;
        break;
      end
    end
    check("t4_timeout_delay", 32'(t0), 32'd20);
    check("t4_idle_after_to", 32'(busy), 32'd0);
    check("t4_no_restart", 32'(cnt_start), 32'(s0));
    wait_grant(idx);
    check("t4_next_req", 32'(idx), 32'd2);
    check("t4_tx_din", 32'(tx_din), 32'h33);
    req = '0;
    serve(2);

    // tx_done on the watchdog expiry cycle: no timeout_err.
    s0 = cnt_to;
    req = 4'b1000;
    wait_grant(idx);
    check("t5_grant3", 32'(idx), 32'd3);
    req = '0;
    serve(19);
    check("t5_no_timeout", 32'(cnt_to), 32'(s0));
    check("t5_idle", 32'(busy), 32'd0);

    // tx_done in IDLE and in LAUNCH is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_start", 32'(tx_start), 32'd0);
    req = 4'b0001;
    wait_grant(idx);
    check("t6_grant0", 32'(idx), 32'd0);
    req = '0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("t6_still_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t6_done", 32'(busy), 32'd0);

    // Reset in WAIT clears everything; first grant afterwards goes to 0.
    req = 4'b1111;
    wait_grant(idx);
    check("t7_grant1", 32'(idx), 32'd1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t7_grant", 32'(grant), 32'd0);
    check("t7_tx_start", 32'(tx_start), 32'd0);
    check("t7_tx_din", 32'(tx_din), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_active_id", 32'(active_id), 32'd0);
    check("t7_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();
    check("t7_first_grant", 32'(grant), 32'h1);
    req = '0;
    serve(2);

    check("onehot_violations", 32'(onehot_bad), 32'd0);
    check("orphan_tx_start", 32'(start_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
